// File: rtl/e5_pipe_pkg.sv
// +----------------------------------------------------------------------+
// | e5_pipe_pkg : shared widths, typedefs and helpers for pipeline stages |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package e5_pipe_pkg;

    localparam int c_BLANK_W    = 4;
    localparam int c_CNT_W      = 16;
    localparam int c_CTRL_W_DEF = 3;

    typedef logic [c_CTRL_W_DEF-1:0] ctrl_t;
    typedef logic [c_CNT_W-1:0]      cnt_t;

    // Saturating increment: the counter sticks at all-ones.
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_blank_ctr.sv
// +----------------------------------------------------------------------+
// | pipe_blank_ctr : post-reset blank window down-counter (falling edge) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pipe_blank_ctr
    import e5_pipe_pkg::*;
#(
    parameter int BLANK_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    output logic blanking
);

    logic [c_BLANK_W-1:0] r_cnt;

    always_ff @(negedge clk) begin
        if (reset) begin
            r_cnt <= c_BLANK_W'(BLANK_CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_BLANK_W'(1);
        end
    end

    assign blanking = (r_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// +----------------------------------------------------------------------+
// | pipe_stage_reg : falling-edge pipeline register with stall, flush,   |
// | post-reset blanking; optional perf counters via PIPE_STAGE_PERF_EN.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pipe_stage_reg
    import e5_pipe_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int CTRL_W       = $bits(ctrl_t),
    parameter int BLANK_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               valid_i,
    input  logic [CTRL_W-1:0]  ctrl_i,
    input  logic [WIDTH-1:0]   data_i,
    output logic               valid_o,
    output logic [CTRL_W-1:0]  ctrl_o,
    output logic [WIDTH-1:0]   data_o,
    output logic               blanking_o,
    output logic [c_CNT_W-1:0] stall_cnt_o,
    output logic [c_CNT_W-1:0] bubble_cnt_o
);

    logic              w_blanking;
    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [WIDTH-1:0]  r_data;

    pipe_blank_ctr #(
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_blank_ctr (
        .clk      (clk),
        .reset    (reset),
        .blanking (w_blanking)
    );

    // Control is gated by valid on load so a dead slot can never write back.
    always_ff @(negedge clk) begin
        if (reset || w_blanking) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (!stall) begin
            r_valid <= valid_i;
            r_ctrl  <= valid_i ? ctrl_i : '0;
            r_data  <= data_i;
        end
    end

    assign valid_o    = r_valid;
    assign ctrl_o     = r_ctrl;
    assign data_o     = r_data;
    assign blanking_o = w_blanking;

`ifdef PIPE_STAGE_PERF_EN
    cnt_t r_stall_cnt;
    cnt_t r_bubble_cnt;

    always_ff @(negedge clk) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (!w_blanking) begin
            if (flush) begin
                r_bubble_cnt <= sat_inc(r_bubble_cnt);
            end else if (stall) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
        end
    end

    assign stall_cnt_o  = r_stall_cnt;
    assign bubble_cnt_o = r_bubble_cnt;
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// +----------------------------------------------------------------------+
// | tb_pipe_stage_reg : scoreboard bench for pipe_stage_reg              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stream A drives the BLANK_CYCLES=2 instance.
    logic        a_reset, a_stall, a_flush, a_valid;
    logic [2:0]  a_ctrl;
    logic [31:0] a_data;
    logic        a_vo, a_bo;
    logic [2:0]  a_co;
    logic [31:0] a_do;
    logic [15:0] a_sc, a_bc;

    // Stream B drives both the BLANK_CYCLES=3 and BLANK_CYCLES=0 instances.
    logic        b_reset, b_stall, b_flush, b_valid;
    logic [2:0]  b_ctrl;
    logic [31:0] b_data;
    logic        t_vo, t_bo, z_vo, z_bo;
    logic [2:0]  t_co, z_co;
    logic [31:0] t_do, z_do;
    logic [15:0] t_sc, t_bc, z_sc, z_bc;

    pipe_stage_reg #(.WIDTH(32), .CTRL_W(3), .BLANK_CYCLES(2)) dut2 (
        .clk(clk), .reset(a_reset), .stall(a_stall), .flush(a_flush),
        .valid_i(a_valid), .ctrl_i(a_ctrl), .data_i(a_data),
        .valid_o(a_vo), .ctrl_o(a_co), .data_o(a_do), .blanking_o(a_bo),
        .stall_cnt_o(a_sc), .bubble_cnt_o(a_bc));

    pipe_stage_reg #(.WIDTH(32), .CTRL_W(3), .BLANK_CYCLES(3)) dut3 (
        .clk(clk), .reset(b_reset), .stall(b_stall), .flush(b_flush),
        .valid_i(b_valid), .ctrl_i(b_ctrl), .data_i(b_data),
        .valid_o(t_vo), .ctrl_o(t_co), .data_o(t_do), .blanking_o(t_bo),
        .stall_cnt_o(t_sc), .bubble_cnt_o(t_bc));

    pipe_stage_reg #(.WIDTH(32), .CTRL_W(3), .BLANK_CYCLES(0)) dut0 (
        .clk(clk), .reset(b_reset), .stall(b_stall), .flush(b_flush),
        .valid_i(b_valid), .ctrl_i(b_ctrl), .data_i(b_data),
        .valid_o(z_vo), .ctrl_o(z_co), .data_o(z_do), .blanking_o(z_bo),
        .stall_cnt_o(z_sc), .bubble_cnt_o(z_bc));

    typedef struct {
        int          sel;
        int          row;
        logic        v;
        logic [2:0]  c;
        logic [31:0] d;
        logic        b;
        logic [15:0] sc;
        logic [15:0] bc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   row_a  = 0;
    int   row_b  = 0;

    // Monitor: everything queued during the previous cycle belongs to the
    // falling edge that has just happened.
    initial begin
        exp_t e;
        logic [68:0] act, exp;
        forever begin
            @(posedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.sel)
                    0:       act = {a_vo, a_co, a_do, a_bo, a_sc, a_bc};
                    1:       act = {t_vo, t_co, t_do, t_bo, t_sc, t_bc};
                    default: act = {z_vo, z_co, z_do, z_bo, z_sc, z_bc};
                endcase
                exp = {e.v, e.c, e.d, e.b, e.sc, e.bc};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL dut%0d row %0d: got v=%b c=%b d=%h blank=%b sc=%0d bc=%0d want v=%b c=%b d=%h blank=%b sc=%0d bc=%0d",
                             e.sel, e.row, act[68], act[67:65], act[64:33], act[32], act[31:16], act[15:0],
                             e.v, e.c, e.d, e.b, e.sc, e.bc);
                end
            end
        end
    end

    function automatic exp_t mk(input int sel, input int row, input logic v, input logic [2:0] c,
                                input logic [31:0] d, input logic b, input int sc, input int bc);
        exp_t e;
        e.sel = sel; e.row = row; e.v = v; e.c = c; e.d = d; e.b = b;
        e.sc  = PERF ? 16'(sc) : 16'h0;
        e.bc  = PERF ? 16'(bc) : 16'h0;
        return e;
    endfunction

    task automatic step_a(input logic rs, input logic st, input logic fl, input logic v,
                          input logic [2:0] c, input logic [31:0] d,
                          input logic ev, input logic [2:0] ec, input logic [31:0] ed,
                          input logic eb, input int esc, input int ebc);
        @(posedge clk); #1;
        a_reset = rs; a_stall = st; a_flush = fl; a_valid = v; a_ctrl = c; a_data = d;
        row_a++;
        q.push_back(mk(0, row_a, ev, ec, ed, eb, esc, ebc));
    endtask

    // Expectations for the BLANK_CYCLES=3 instance (t*) and BLANK_CYCLES=0 instance (z*).
    task automatic step_b(input logic rs, input logic fl, input logic v,
                          input logic [2:0] c, input logic [31:0] d,
                          input logic tv, input logic [2:0] tc, input logic [31:0] td,
                          input logic tb, input int tbc,
                          input logic zv, input logic [2:0] zc, input logic [31:0] zd,
                          input logic zb, input int zbc);
        @(posedge clk); #1;
        b_reset = rs; b_stall = 1'b0; b_flush = fl; b_valid = v; b_ctrl = c; b_data = d;
        row_b++;
        q.push_back(mk(1, row_b, tv, tc, td, tb, 0, tbc));
        q.push_back(mk(2, row_b, zv, zc, zd, zb, 0, zbc));
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        a_reset = 1'b1; a_stall = 1'b0; a_flush = 1'b0; a_valid = 1'b0; a_ctrl = '0; a_data = '0;
        b_reset = 1'b1; b_stall = 1'b0; b_flush = 1'b0; b_valid = 1'b0; b_ctrl = '0; b_data = '0;

        //     rs st fl v  ctrl    data          | v  ctrl    data          bl sc bc
        step_a(1, 0, 0, 1, 3'b000, 32'hA5A5_0001,  0, 3'b000, 32'h0,        1, 0, 0);
        step_a(0, 0, 0, 1, 3'b010, 32'hA5A5_0001,  0, 3'b000, 32'h0,        1, 0, 0);
        step_a(0, 0, 0, 1, 3'b010, 32'hA5A5_0001,  0, 3'b000, 32'h0,        0, 0, 0);
        step_a(0, 0, 0, 1, 3'b010, 32'hA5A5_0001,  1, 3'b010, 32'hA5A5_0001, 0, 0, 0);
        step_a(0, 0, 0, 1, 3'b101, 32'h0000_1234,  1, 3'b101, 32'h0000_1234, 0, 0, 0);
        step_a(0, 1, 0, 0, 3'b011, 32'h0000_FFFF,  1, 3'b101, 32'h0000_1234, 0, 1, 0);
        step_a(0, 1, 0, 1, 3'b110, 32'h0000_EEEE,  1, 3'b101, 32'h0000_1234, 0, 2, 0);
        step_a(0, 1, 0, 1, 3'b111, 32'h0000_DDDD,  1, 3'b101, 32'h0000_1234, 0, 3, 0);
        step_a(0, 1, 1, 1, 3'b111, 32'h0000_CCCC,  0, 3'b000, 32'h0000_1234, 0, 3, 1);
        step_a(0, 0, 0, 0, 3'b111, 32'h0000_0055,  0, 3'b000, 32'h0000_0055, 0, 3, 1);
        step_a(0, 0, 0, 1, 3'b110, 32'h0000_CAFE,  1, 3'b110, 32'h0000_CAFE, 0, 3, 1);
        step_a(0, 0, 1, 1, 3'b011, 32'h0000_1111,  0, 3'b000, 32'h0000_CAFE, 0, 3, 2);
        step_a(0, 0, 0, 1, 3'b001, 32'h0000_BEEF,  1, 3'b001, 32'h0000_BEEF, 0, 3, 2);
        step_a(1, 0, 0, 1, 3'b010, 32'h0000_0077,  0, 3'b000, 32'h0,        1, 0, 0);
        step_a(0, 1, 1, 1, 3'b111, 32'h0000_0099,  0, 3'b000, 32'h0,        1, 0, 0);
        step_a(0, 1, 1, 1, 3'b111, 32'h0000_0099,  0, 3'b000, 32'h0,        0, 0, 0);
        step_a(0, 1, 0, 1, 3'b111, 32'h0000_0099,  0, 3'b000, 32'h0,        0, 1, 0);
        step_a(0, 0, 0, 1, 3'b010, 32'h0000_0001,  1, 3'b010, 32'h0000_0001, 0, 1, 0);
        drain();

        //     rs fl v  ctrl    data   | BLANK=3: v c d bl bc      | BLANK=0: v c d bl bc
        step_b(1, 0, 1, 3'b011, 32'h10, 0, 3'b000, 32'h0,  1, 0,   0, 3'b000, 32'h0,  0, 0);
        step_b(0, 0, 1, 3'b011, 32'h11, 0, 3'b000, 32'h0,  1, 0,   1, 3'b011, 32'h11, 0, 0);
        step_b(0, 1, 1, 3'b011, 32'h12, 0, 3'b000, 32'h0,  1, 0,   0, 3'b000, 32'h11, 0, 1);
        step_b(0, 0, 1, 3'b100, 32'h13, 0, 3'b000, 32'h0,  0, 0,   1, 3'b100, 32'h13, 0, 1);
        step_b(0, 0, 1, 3'b101, 32'h14, 1, 3'b101, 32'h14, 0, 0,   1, 3'b101, 32'h14, 0, 1);
        drain();

        // Long stall run on the BLANK_CYCLES=2 instance to reach saturation.
        @(posedge clk); #1;
        a_reset = 1'b0; a_stall = 1'b1; a_flush = 1'b0;
        repeat (65540) @(negedge clk);
        @(posedge clk);
        checks++;
        if (a_sc !== (PERF ? 16'hFFFF : 16'h0) || a_bc !== 16'h0 ||
            a_vo !== 1'b1 || a_do !== 32'h0000_0001) begin
            errors++;
            $display("FAIL saturate: got sc=%h bc=%h v=%b d=%h want sc=%h bc=0000 v=1 d=00000001",
                     a_sc, a_bc, a_vo, a_do, PERF ? 16'hFFFF : 16'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload (data) width in bits, at least 1.
REQ-002 SHALL have parameter CTRL_W, default 3: control field width in bits (e.g. ResultSrc plus RegWrite), at least 1.
REQ-003 SHALL have parameter BLANK_CYCLES, default 1: number of post-reset cycles with outputs held cleared, range 0..15.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the falling edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port stall, input, 1 bit: hold the current contents.
REQ-007 SHALL have port flush, input, 1 bit: insert a bubble.
REQ-008 SHALL have port valid_i, input, 1 bit: upstream stage holds a live instruction.
REQ-009 SHALL have port ctrl_i, input, CTRL_W bits: upstream control field.
REQ-010 SHALL have port data_i, input, WIDTH bits: upstream payload.
REQ-011 SHALL have port valid_o, output, 1 bit: registered valid.
REQ-012 SHALL have port ctrl_o, output, CTRL_W bits: registered control field.
REQ-013 SHALL have port data_o, output, WIDTH bits: registered payload.
REQ-014 SHALL have port blanking_o, output, 1 bit: high while the post-reset blank window is active.
REQ-015 SHALL have port stall_cnt_o, output, 16 bits: number of stalled cycles.
REQ-016 SHALL have port bubble_cnt_o, output, 16 bits: number of bubbles inserted.

Function
REQ-017 SHALL evaluate, on each falling clk edge, in priority order: reset > blanking > flush > stall > load.
REQ-018 SHALL, on load, register valid_i, ctrl_i and data_i, giving one-cycle latency.
REQ-019 SHALL, on stall without flush, hold valid_o, ctrl_o and data_o unchanged.
REQ-020 SHALL, on flush (stall ignored), set valid_o=0 and ctrl_o=0 and leave data_o unchanged.
REQ-021 SHALL, while blanking, force valid_o=0, ctrl_o=0 and data_o=0, ignoring stall and flush.
REQ-022 SHALL implement the blank counter as: load BLANK_CYCLES on reset; decrement once per non-reset edge until 0; blanking_o=1 while the count is nonzero.
REQ-023 SHALL, when BLANK_CYCLES=0, never assert blanking_o, so the first edge after reset is a normal load.
REQ-024 SHALL keep the blank counter decrementing regardless of stall and flush.
REQ-025 SHALL produce ctrl_o=0 whenever valid_o=0, so a bubble never writes the register file.

Reset
REQ-026 SHALL, on reset=1 at a falling edge, clear valid_o, ctrl_o, data_o, stall_cnt_o and bubble_cnt_o to 0 and set blanking_o=(BLANK_CYCLES!=0).
REQ-027 SHALL treat a mid-operation reset like a power-on reset: it discards the in-flight contents and restarts the blank window.

Configuration
REQ-028 SHALL, with PIPE_STAGE_PERF_EN defined, increment stall_cnt_o on each non-blanking edge with stall=1 and flush=0.
REQ-029 SHALL, with PIPE_STAGE_PERF_EN defined, increment bubble_cnt_o on each non-blanking edge with flush=1.
REQ-030 SHALL saturate both counters at 16'hFFFF.
REQ-031 SHALL, without PIPE_STAGE_PERF_EN, keep both counter ports present but tied to 0, with no counter flops.

Structure
REQ-032 SHALL take the blank-count width constant, the counter width constant (16) and the ctrl-field typedef from the shared package e5_pipe_pkg.
REQ-033 SHALL implement the blank counter as the single sub-module pipe_blank_ctr (inputs: clk, reset; parameter BLANK_CYCLES; output blanking).

Verification
REQ-034 SHALL cover post-reset blanking: BLANK_CYCLES=2, reset for 1 edge, valid_i=1, data_i=32'hA5A5_0001 -> outputs 0 for 2 edges, then data_o=32'hA5A5_0001 and valid_o=1 on edge 3.
REQ-035 SHALL cover stall hold: load ctrl_i=3'b101, data_i=32'h1234, then stall=1 for 3 edges with new inputs -> ctrl_o=3'b101, data_o=32'h1234 held; stall_cnt_o=3 with PERF enabled.
REQ-036 SHALL cover simultaneous flush and stall: flush=1, stall=1 -> next edge valid_o=0, ctrl_o=0, data_o held; bubble_cnt_o=1 and stall_cnt_o unchanged.
REQ-037 SHALL cover flush during blanking: BLANK_CYCLES=3, flush=1 on edge 2 -> bubble_cnt_o stays 0 and blanking_o falls after edge 3.
REQ-038 SHALL cover mid-operation reset: valid stream loaded, reset=1 for 1 edge -> all outputs 0 and blanking_o=1 on the same edge.
REQ-039 SHALL cover counter saturation: force stall for 65540 edges -> stall_cnt_o=16'hFFFF; without PIPE_STAGE_PERF_EN both counters read 0 throughout.
